map_ss_seq: RTL and testbench

// Save-state sequencer: initiator side of the mapper ss_ctrl interface (ss_act/ss_we/ss_addr/data).
// On a save command it walks mapper state addresses 0..SS_LEN-1 and streams each ss_rdat byte out.
// On a load command it pulls bytes from an input stream and writes them back into the mapper.

---
 rtl/map_ss_seq.sv | 180 ++++++++++++++++++
 tb/tb_map_ss_seq.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_ss_seq.sv
// map_ss_seq: save-state sequencer, the initiator side of the mapper ss_ctrl port.
//
// Save: walks ss_addr 0..SS_LEN-1. The byte on ss_rdat is captured on each detected
// m2 falling edge and offered on out_data/out_valid until out_ready accepts it.
// Load: pulls bytes from in_data/in_valid and presents each one on ss_wdat with ss_we
// for exactly one m2 falling edge, which is when the mapper latches it.
//
// Ports
//   clk, rst_n             system clock, async active-low reset
//   m2                     CPU M2 phase, asynchronous to clk
//   cmd_save, cmd_load     1-clk start pulses (save wins; ignored while busy)
//   busy, done, err        status: in progress / completion pulse / sticky timeout
//   ss_act, ss_we          access active / write qualifier to the mapper
//   ss_addr, ss_wdat       state address / write data to the mapper
//   ss_rdat                mapper read data, combinational on ss_addr
//   out_data/valid/ready   saved byte stream (out)
//   in_data/valid/ready    restored byte stream (in)
module map_ss_seq #(
  parameter int SS_LEN  = 256,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m2,
  input  logic       cmd_save,
  input  logic       cmd_load,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    LAST     = 8'(SS_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, S_WAIT, S_PUSH, L_PULL, L_WAIT, FIN} state_t;
  state_t state;

  // m2 shift register: [0],[1] synchronizer, [2] history.
  logic [2:0]    m2_pipe;
  logic          m2_fall;
  logic          m2_fall_q;   // high in the clk right after a detected fall
  logic [TW-1:0] tmo_cnt;
  logic          wait_st;
  logic          tmo_hit;

  assign m2_fall = m2_pipe[2] & ~m2_pipe[1];
  assign wait_st = (state == S_WAIT) || (state == L_WAIT) || (state == FIN);
  // A real fall always wins over an expiring count.
  assign tmo_hit = wait_st && !m2_fall && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      m2_pipe   <= '0;
      m2_fall_q <= 1'b0;
      tmo_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ss_act    <= 1'b0;
      ss_we     <= 1'b0;
      ss_addr   <= '0;
      ss_wdat   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      m2_pipe   <= {m2_pipe[1:0], m2};
      m2_fall_q <= m2_fall;
      done      <= 1'b0;
      // Every entry into a wait state comes either from a non-wait state (count
      // already 0) or on an m2 fall, so this one line also covers the reset on entry.
      tmo_cnt   <= (wait_st && !m2_fall) ? tmo_cnt + TW'(1) : '0;

      if (tmo_hit) begin
        err       <= 1'b1;
        ss_act    <= 1'b0;
        ss_we     <= 1'b0;
        out_valid <= 1'b0;
        in_ready  <= 1'b0;
        busy      <= 1'b0;
        state     <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_save || cmd_load) begin
              busy    <= 1'b1;
              ss_act  <= 1'b1;
              ss_we   <= 1'b0;
              ss_addr <= '0;
              err     <= 1'b0;
              if (cmd_save) begin
                state <= S_WAIT;
              end else begin
                in_ready <= 1'b1;
                state    <= L_PULL;
              end
            end
          end

          S_WAIT: begin
            if (m2_fall) begin
              out_data  <= ss_rdat;
              out_valid <= 1'b1;
              state     <= S_PUSH;
            end
          end

          S_PUSH: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (ss_addr == LAST) begin
                state <= FIN;
              end else begin
                ss_addr <= ss_addr + 8'd1;
                state   <= S_WAIT;
              end
            end
          end

          L_PULL: begin
            if (in_valid && in_ready) begin
              ss_wdat  <= in_data;
              in_ready <= 1'b0;
              // Raise ss_we only right after a detected fall. A byte that arrives
              // later (stream stall) could otherwise land in the gap between a pin
              // edge and its detection and never be latched; such a write is
              // armed on the next fall in L_WAIT instead.
              ss_we    <= m2_fall_q;
              state    <= L_WAIT;
            end
          end

          L_WAIT: begin
            if (m2_fall) begin
              if (!ss_we) begin
                ss_we <= 1'b1;
              end else begin
                // The mapper latched the byte at the edge just detected.
                ss_we <= 1'b0;
                if (ss_addr == LAST) begin
                  state <= FIN;
                end else begin
                  ss_addr  <= ss_addr + 8'd1;
                  in_ready <= 1'b1;
                  state    <= L_PULL;
                end
              end
            end
          end

          FIN: begin
            // One settle edge with ss_act high and ss_we low before releasing.
            if (m2_fall) begin
              ss_act <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_map_ss_seq.sv
// Directed bench for map_ss_seq. Two instances share clk/rst_n/m2 and the streams:
//   dut_a: SS_LEN=4,   TIMEOUT=64, mapper read data = addr ^ A5
//   dut_b: SS_LEN=256, TIMEOUT=64, mapper read data = addr ^ 3C, write model on negedge m2
// m2 runs at 28 clk per period, edges placed 3 ns after a clk rising edge.
module tb_map_ss_seq;

  logic       clk, rst_n, m2;
  logic       cmd_save_a, cmd_load_a, cmd_save_b, cmd_load_b;
  logic       out_ready;
  logic [7:0] in_data;
  logic       in_valid;

  logic       busy_a, done_a, err_a, ss_act_a, ss_we_a, out_valid_a, in_ready_a;
  logic [7:0] ss_addr_a, ss_wdat_a, ss_rdat_a, out_data_a;
  logic       busy_b, done_b, err_b, ss_act_b, ss_we_b, out_valid_b, in_ready_b;
  logic [7:0] ss_addr_b, ss_wdat_b, ss_rdat_b, out_data_b;

  assign ss_rdat_a = ss_addr_a ^ 8'hA5;
  assign ss_rdat_b = ss_addr_b ^ 8'h3C;

  map_ss_seq #(.SS_LEN(4), .TIMEOUT(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .m2(m2), .cmd_save(cmd_save_a), .cmd_load(cmd_load_a),
    .busy(busy_a), .done(done_a), .err(err_a), .ss_act(ss_act_a), .ss_we(ss_we_a),
    .ss_addr(ss_addr_a), .ss_wdat(ss_wdat_a), .ss_rdat(ss_rdat_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a));

  map_ss_seq #(.SS_LEN(256), .TIMEOUT(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .m2(m2), .cmd_save(cmd_save_b), .cmd_load(cmd_load_b),
    .busy(busy_b), .done(done_b), .err(err_b), .ss_act(ss_act_b), .ss_we(ss_we_b),
    .ss_addr(ss_addr_b), .ss_wdat(ss_wdat_b), .ss_rdat(ss_rdat_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b));

  int total, bad;

  logic       m2_run, mon_clr, feed_en;
  logic [1:0] rdy_mode;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // m2: 14 clk high / 14 clk low, freezes where it is when m2_run drops.
  initial begin
    int cnt;
    cnt = 0;
    m2  = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (m2_run) begin
        if (cnt == 13) begin
          cnt = 0;
          m2  = ~m2;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Input stream: byte k carries k+1; advances after each observed handshake.
  initial begin
    int   k;
    logic hs_pend;
    k = 0; hs_pend = 1'b0; in_data = 8'd1; in_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!feed_en) begin
        k = 0; hs_pend = 1'b0; in_data = 8'd1; in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        if (hs_pend) begin
          k++;
          in_data = 8'(k + 1);
        end
        hs_pend = in_ready_b;
      end
    end
  end

  // Output-side monitor and out_ready driver.
  logic [7:0] q_a[$], q_b[$];
  int   we_a_n, irdy_a_n, done_a_n, done_b_n, stab_a, stab_b, act_drop, we_b_rise;
  initial begin
    int         stall;
    logic       long_done, pv_a, ph_a, pv_b, ph_b, pwe_b;
    logic [7:0] pd_a, pd_b;
    out_ready = 1'b0;
    stall = 0; long_done = 1'b0;
    we_a_n = 0; irdy_a_n = 0; done_a_n = 0; done_b_n = 0;
    stab_a = 0; stab_b = 0; act_drop = 0; we_b_rise = 0;
    pv_a = 1'b0; ph_a = 1'b0; pv_b = 1'b0; ph_b = 1'b0; pwe_b = 1'b0;
    pd_a = '0; pd_b = '0;
    forever begin
      @(negedge clk);
      if (mon_clr) begin
        q_a.delete(); q_b.delete();
        we_a_n = 0; irdy_a_n = 0; done_a_n = 0; done_b_n = 0;
        stab_a = 0; stab_b = 0; act_drop = 0; stall = 0; long_done = 1'b0;
      end
      case (rdy_mode)
        2'd0: out_ready = 1'b0;
        2'd1: out_ready = 1'b1;
        default: begin
          if (!long_done && q_b.size() == 100) begin
            stall = 100;
            long_done = 1'b1;
          end
          if (stall > 0) begin
            out_ready = 1'b0;
            stall--;
            if (!ss_act_b) act_drop++;
          end else begin
            out_ready = ($urandom_range(0, 2) != 0);
          end
        end
      endcase
      if (pv_a && !ph_a && (!out_valid_a || out_data_a !== pd_a)) stab_a++;
      if (pv_b && !ph_b && (!out_valid_b || out_data_b !== pd_b)) stab_b++;
      if (out_valid_a && out_ready) q_a.push_back(out_data_a);
      if (out_valid_b && out_ready) q_b.push_back(out_data_b);
      if (ss_we_a) we_a_n++;
      if (in_ready_a) irdy_a_n++;
      if (done_a) done_a_n++;
      if (done_b) done_b_n++;
      if (ss_we_b && !pwe_b) we_b_rise++;
      pwe_b = ss_we_b;
      pv_a = out_valid_a; pd_a = out_data_a; ph_a = out_valid_a && out_ready;
      pv_b = out_valid_b; pd_b = out_data_b; ph_b = out_valid_b && out_ready;
    end
  end

  // Mapper write model for dut_b: latches on the m2 falling edge.
  logic [7:0] log_addr [1024];
  logic [7:0] log_dat  [1024];
  int log_n, dup_n;
  initial begin
    int last_id;
    log_n = 0; dup_n = 0; last_id = -1;
    forever begin
      @(negedge m2);
      if (ss_act_b && ss_we_b) begin
        if (last_id == we_b_rise) dup_n++;
        last_id = we_b_rise;
        if (log_n < 1024) begin
          log_addr[log_n] = ss_addr_b;
          log_dat[log_n]  = ss_wdat_b;
        end
        log_n++;
      end
    end
  end

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy_a, done_a, err_a, ss_act_a, ss_we_a, out_valid_a, in_ready_a} !== 7'b0) begin
      bad++;
      $display("FAIL reset_flags_a got=%b want=0000000",
               {busy_a, done_a, err_a, ss_act_a, ss_we_a, out_valid_a, in_ready_a});
    end
    total++;
    if ({ss_addr_a, ss_wdat_a, out_data_a} !== 24'h0) begin
      bad++;
      $display("FAIL reset_data_a got=%h want=000000", {ss_addr_a, ss_wdat_a, out_data_a});
    end
    total++;
    if ({busy_b, done_b, err_b, ss_act_b, ss_we_b, out_valid_b, in_ready_b, ss_addr_b} !== 15'h0) begin
      bad++;
      $display("FAIL reset_b got=%h want=0",
               {busy_b, done_b, err_b, ss_act_b, ss_we_b, out_valid_b, in_ready_b, ss_addr_b});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if ({busy_a, busy_b, ss_act_a, ss_act_b, done_a, done_b} !== 6'b0) begin
      bad++;
      $display("FAIL idle_after_reset got=%b want=000000",
               {busy_a, busy_b, ss_act_a, ss_act_b, done_a, done_b});
    end
  endtask

  task automatic test_save_basic();
    logic [7:0] exp [4];
    int n, errs;
    exp[0] = 8'hA5; exp[1] = 8'hA4; exp[2] = 8'hA7; exp[3] = 8'hA6;
    rdy_mode = 2'd1;
    clr_mon();
    @(negedge clk); cmd_save_a = 1'b1;
    @(negedge clk); cmd_save_a = 1'b0;
    total++;
    if ({busy_a, ss_act_a, in_ready_a} !== 3'b110) begin
      bad++;
      $display("FAIL save_accept got=%b want=110", {busy_a, ss_act_a, in_ready_a});
    end
    n = 0;
    while (done_a_n == 0 && n < 3000) begin @(negedge clk); #1; n++; end
    total++;
    if (done_a_n == 0) begin bad++; $display("FAIL save_done_timeout got=%0d want=1", done_a_n); end
    total++;
    if (q_a.size() != 4) begin bad++; $display("FAIL save_count got=%0d want=4", q_a.size()); end
    errs = 0;
    for (int i = 0; i < 4 && i < q_a.size(); i++) if (q_a[i] !== exp[i]) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL save_bytes got=%p want=A5,A4,A7,A6", q_a);
    end
    total++;
    if (we_a_n != 0) begin bad++; $display("FAIL save_we_seen got=%0d want=0", we_a_n); end
    total++;
    if ({busy_a, ss_act_a, err_a, out_valid_a} !== 4'b0) begin
      bad++;
      $display("FAIL save_end_flags got=%b want=0000", {busy_a, ss_act_a, err_a, out_valid_a});
    end
    repeat (60) @(negedge clk);
    #1;
    total++;
    if (done_a_n != 1 || stab_a != 0) begin
      bad++;
      $display("FAIL save_done_once got=%0d/%0d want=1/0", done_a_n, stab_a);
    end
  endtask

  task automatic test_cmd_priority();
    int n, errs;
    rdy_mode = 2'd1;
    clr_mon();
    @(negedge clk); cmd_save_a = 1'b1; cmd_load_a = 1'b1;
    @(negedge clk); cmd_save_a = 1'b0; cmd_load_a = 1'b0;
    total++;
    if ({busy_a, in_ready_a} !== 2'b10) begin
      bad++;
      $display("FAIL both_cmd_save_wins got=%b want=10", {busy_a, in_ready_a});
    end
    repeat (20) @(negedge clk);
    cmd_load_a = 1'b1; cmd_save_a = 1'b1;
    @(negedge clk); cmd_load_a = 1'b0; cmd_save_a = 1'b0;
    n = 0;
    while (done_a_n == 0 && n < 3000) begin @(negedge clk); #1; n++; end
    repeat (60) @(negedge clk);
    #1;
    errs = 0;
    for (int i = 0; i < q_a.size(); i++) if (q_a[i] !== (8'(i) ^ 8'hA5)) errs++;
    total++;
    if (q_a.size() != 4 || errs != 0) begin
      bad++;
      $display("FAIL busy_cmd_ignored got=%0d bytes/%0d bad want=4/0", q_a.size(), errs);
    end
    total++;
    if (irdy_a_n != 0 || we_a_n != 0 || done_a_n != 1 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL priority_side got=irdy%0d we%0d done%0d busy%b want=0 0 1 0",
               irdy_a_n, we_a_n, done_a_n, busy_a);
    end
  endtask

  task automatic test_save_stall();
    int n, errs;
    rdy_mode = 2'd2;
    clr_mon();
    @(negedge clk); cmd_save_b = 1'b1;
    @(negedge clk); cmd_save_b = 1'b0;
    n = 0;
    while (done_b_n == 0 && n < 40000) begin @(negedge clk); #1; n++; end
    rdy_mode = 2'd1;
    total++;
    if (done_b_n != 1) begin bad++; $display("FAIL stall_done got=%0d want=1", done_b_n); end
    total++;
    if (q_b.size() != 256) begin bad++; $display("FAIL stall_count got=%0d want=256", q_b.size()); end
    errs = 0;
    for (int i = 0; i < q_b.size(); i++) if (q_b[i] !== (8'(i) ^ 8'h3C)) errs++;
    total++;
    if (errs != 0) begin bad++; $display("FAIL stall_bytes got=%0d wrong want=0", errs); end
    total++;
    if (stab_b != 0 || act_drop != 0 || err_b !== 1'b0) begin
      bad++;
      $display("FAIL stall_hold got=stab%0d drop%0d err%b want=0 0 0", stab_b, act_drop, err_b);
    end
  endtask

  task automatic test_timeout();
    int n;
    rdy_mode = 2'd1;
    clr_mon();
    @(negedge clk); cmd_save_b = 1'b1;
    @(negedge clk); cmd_save_b = 1'b0;
    n = 0;
    while (q_b.size() < 10 && n < 2000) begin @(negedge clk); #1; n++; end
    m2_run = 1'b0;
    n = 0;
    while (!err_b && n < 200) begin @(negedge clk); n++; end
    total++;
    if (n < 63 || n > 67) begin bad++; $display("FAIL tmo_latency got=%0d want=65", n); end
    total++;
    if ({err_b, ss_act_b, busy_b, out_valid_b, ss_we_b, in_ready_b} !== 6'b100000) begin
      bad++;
      $display("FAIL tmo_flags got=%b want=100000",
               {err_b, ss_act_b, busy_b, out_valid_b, ss_we_b, in_ready_b});
    end
    repeat (20) @(negedge clk);
    #1;
    total++;
    if (err_b !== 1'b1 || done_b_n != 0 || q_b.size() != 10) begin
      bad++;
      $display("FAIL tmo_sticky got=err%b done%0d bytes%0d want=1 0 10", err_b, done_b_n, q_b.size());
    end
  endtask

  task automatic test_reset_mid_load();
    int n, errs, log0, dup0, rise0;
    m2_run  = 1'b1;
    feed_en = 1'b1;
    clr_mon();
    @(negedge clk); cmd_load_b = 1'b1;
    @(negedge clk); cmd_load_b = 1'b0;
    total++;
    if ({err_b, busy_b, in_ready_b} !== 3'b011) begin
      bad++;
      $display("FAIL load_clears_err got=%b want=011", {err_b, busy_b, in_ready_b});
    end
    n = 0;
    while (!ss_we_b && n < 300) begin @(negedge clk); n++; end
    total++;
    if (!ss_we_b) begin bad++; $display("FAIL load_we_rise got=0 want=1"); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy_b, ss_act_b, ss_we_b, in_ready_b, ss_addr_b, ss_wdat_b} !== 20'h0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0",
               {busy_b, ss_act_b, ss_we_b, in_ready_b, ss_addr_b, ss_wdat_b});
    end
    feed_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    feed_en = 1'b1;
    log0 = log_n; dup0 = dup_n; rise0 = we_b_rise;
    clr_mon();
    @(negedge clk); cmd_load_b = 1'b1;
    @(negedge clk); cmd_load_b = 1'b0;
    n = 0;
    while (done_b_n == 0 && n < 20000) begin @(negedge clk); #1; n++; end
    feed_en = 1'b0;
    total++;
    if (done_b_n != 1 || busy_b !== 1'b0 || ss_act_b !== 1'b0) begin
      bad++;
      $display("FAIL load_done got=done%0d busy%b act%b want=1 0 0", done_b_n, busy_b, ss_act_b);
    end
    total++;
    if (log_n - log0 != 256) begin bad++; $display("FAIL load_writes got=%0d want=256", log_n - log0); end
    errs = 0;
    for (int j = 0; j < 256 && log0 + j < 1024; j++)
      if (log_addr[log0 + j] !== 8'(j) || log_dat[log0 + j] !== 8'(j + 1)) errs++;
    total++;
    if (errs != 0) begin bad++; $display("FAIL load_data got=%0d wrong want=0", errs); end
    total++;
    if (log_addr[log0 + 255] !== 8'hFF || log_dat[log0 + 255] !== 8'h00) begin
      bad++;
      $display("FAIL load_last got=%h:%h want=ff:00", log_addr[log0 + 255], log_dat[log0 + 255]);
    end
    total++;
    if (dup_n != dup0 || we_b_rise - rise0 != 256 || err_b !== 1'b0) begin
      bad++;
      $display("FAIL load_we_span got=dup%0d pulses%0d err%b want=0 256 0",
               dup_n - dup0, we_b_rise - rise0, err_b);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    cmd_save_a = 1'b0; cmd_load_a = 1'b0; cmd_save_b = 1'b0; cmd_load_b = 1'b0;
    rdy_mode = 2'd0; mon_clr = 1'b0; m2_run = 1'b1; feed_en = 1'b0;
    test_reset();
    test_save_basic();
    test_cmd_priority();
    test_save_stall();
    test_timeout();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
